// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the MIPS datapath.
// NRD combinational read ports, two clocked write ports (port 1 wins on
// address conflict), optional write-to-read bypass, optional hardwired
// zero register, and a per-register pending scoreboard for RAW stalls.
module regfile_mp #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned AW       = 5,
   parameter int unsigned NRD      = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           we,
   input  logic [2*AW-1:0]      wa,
   input  logic [2*WIDTH-1:0]   wd,
   input  logic [NRD*AW-1:0]    ra,
   output logic [NRD*WIDTH-1:0] rd,
   input  logic                 set_en,
   input  logic [AW-1:0]        set_addr,
   output logic [NRD-1:0]       rd_pend
);

   localparam int unsigned DEPTH = 1 << AW;

   // Packed storage so the whole array can be cleared in one assignment.
   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [DEPTH-1:0]            pend;
   logic [DEPTH-1:0]            pend_nxt;

   logic [AW-1:0]    wa_p [2];
   logic [WIDTH-1:0] wd_p [2];
   logic [1:0]       wr_ok;

   // Unpack write ports; a write to r0 is dropped when it is hardwired.
   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         wa_p[i]  = wa[i*AW +: AW];
         wd_p[i]  = wd[i*WIDTH +: WIDTH];
         wr_ok[i] = we[i] && !((ZERO_REG != 0) && (wa_p[i] == '0));
      end
   end

   // Register storage; port 1 is written last so it wins on a conflict.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem <= '0;
      end else begin
         if (wr_ok[0]) mem[wa_p[0]] <= wd_p[0];
         if (wr_ok[1]) mem[wa_p[1]] <= wd_p[1];
      end
   end

   // Next scoreboard state: writes clear, a new producer sets and wins.
   always_comb begin
      pend_nxt = pend;
      if (we[0]) pend_nxt[wa_p[0]] = 1'b0;
      if (we[1]) pend_nxt[wa_p[1]] = 1'b0;
      if (set_en) pend_nxt[set_addr] = 1'b1;
      if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
      end else begin
         pend <= pend_nxt;
      end
   end

   // Read ports: storage, then bypass (port 1 over port 0), then the
   // zero register, then reset, each overriding the previous choice.
   always_comb begin
      logic [AW-1:0]    a;
      logic [WIDTH-1:0] d;
      logic             p;
      rd      = '0;
      rd_pend = '0;
      a       = '0;
      d       = '0;
      p       = 1'b0;
      for (int unsigned j = 0; j < NRD; j++) begin
         a = ra[j*AW +: AW];
         d = mem[a];
         p = pend[a];
         if (BYPASS != 0) begin
            if (we[0] && (wa_p[0] == a)) begin
               d = wd_p[0];
               p = 1'b0;
            end
            if (we[1] && (wa_p[1] == a)) begin
               d = wd_p[1];
               p = 1'b0;
            end
         end
         if ((ZERO_REG != 0) && (a == '0)) begin
            d = '0;
            p = 1'b0;
         end
         if (reset) begin
            d = '0;
            p = 1'b0;
         end
         rd[j*WIDTH +: WIDTH] = d;
         rd_pend[j]           = p;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp: default configuration, a
// no-bypass/no-zero-register variant, and a narrow 4-read-port variant.
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  we;
   logic [9:0]  wa;
   logic [63:0] wd;
   logic [9:0]  ra;
   logic        set_en;
   logic [4:0]  set_addr;
   logic [63:0] rd_a, rd_b;
   logic [1:0]  pend_a, pend_b;

   logic [1:0]  s_we;
   logic [5:0]  s_wa;
   logic [31:0] s_wd;
   logic [11:0] s_ra;
   logic        s_set_en;
   logic [2:0]  s_set_addr;
   logic [63:0] s_rd;
   logic [3:0]  s_pend;

   int total = 0;
   int bad   = 0;

   regfile_mp #(.WIDTH(32), .AW(5), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a),
      .set_en(set_en), .set_addr(set_addr), .rd_pend(pend_a));

   regfile_mp #(.WIDTH(32), .AW(5), .NRD(2), .ZERO_REG(0), .BYPASS(0)) u_b (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
      .set_en(set_en), .set_addr(set_addr), .rd_pend(pend_b));

   regfile_mp #(.WIDTH(16), .AW(3), .NRD(4), .ZERO_REG(1), .BYPASS(1)) u_s (
      .clk(clk), .reset(reset), .we(s_we), .wa(s_wa), .wd(s_wd), .ra(s_ra), .rd(s_rd),
      .set_en(s_set_en), .set_addr(s_set_addr), .rd_pend(s_pend));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 2'b00; set_en = 1'b0; s_we = 2'b00; s_set_en = 1'b0;
   endtask

   task automatic test_reset();
      we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF};
      set_en = 1'b1; set_addr = 5'd5; ra = {5'd5, 5'd5};
      #2;
      total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL rst_hold_rd_a got=%h exp=%h", rd_a, 64'h0); end
      total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL rst_hold_pend_a got=%b exp=%b", pend_a, 2'b00); end
      total++; if (rd_b !== 64'h0) begin bad++; $display("FAIL rst_hold_rd_b got=%h exp=%h", rd_b, 64'h0); end
      step();
      reset = 1'b0; idle();
      #2;
      for (int a = 0; a < 32; a++) begin
         ra = {5'(31 - a), 5'(a)};
         #1;
         total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL rst_rd_a a=%0d got=%h exp=%h", a, rd_a, 64'h0); end
         total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL rst_pend_a a=%0d got=%b exp=%b", a, pend_a, 2'b00); end
         total++; if (rd_b !== 64'h0) begin bad++; $display("FAIL rst_rd_b a=%0d got=%h exp=%h", a, rd_b, 64'h0); end
         total++; if (pend_b !== 2'b00) begin bad++; $display("FAIL rst_pend_b a=%0d got=%b exp=%b", a, pend_b, 2'b00); end
      end
      ra = {5'd5, 5'd5};
      #1;
      total++; if (rd_a[31:0] !== 32'h0) begin bad++; $display("FAIL rst_r5 got=%h exp=%h", rd_a[31:0], 32'h0); end
      total++; if (s_rd !== 64'h0) begin bad++; $display("FAIL rst_s_rd got=%h exp=%h", s_rd, 64'h0); end
      total++; if (s_pend !== 4'h0) begin bad++; $display("FAIL rst_s_pend got=%b exp=%b", s_pend, 4'h0); end
   endtask

   task automatic test_conflict();
      step();
      we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22222222, 32'h11111111}; ra = {5'd0, 5'd7};
      #2;
      total++; if (rd_a[31:0] !== 32'h22222222) begin bad++; $display("FAIL conf_byp_a got=%h exp=%h", rd_a[31:0], 32'h22222222); end
      total++; if (rd_b[31:0] !== 32'h0) begin bad++; $display("FAIL conf_old_b got=%h exp=%h", rd_b[31:0], 32'h0); end
      total++; if (rd_a[63:32] !== 32'h0) begin bad++; $display("FAIL conf_r0_a got=%h exp=%h", rd_a[63:32], 32'h0); end
      step(); idle();
      #2;
      total++; if (rd_a[31:0] !== 32'h22222222) begin bad++; $display("FAIL conf_a got=%h exp=%h", rd_a[31:0], 32'h22222222); end
      total++; if (rd_b[31:0] !== 32'h22222222) begin bad++; $display("FAIL conf_b got=%h exp=%h", rd_b[31:0], 32'h22222222); end
   endtask

   task automatic test_bypass();
      step();
      we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'hA5A5A5A5};
      step();
      we = 2'b10; wa = {5'd3, 5'd0}; wd = {32'h12345678, 32'h0}; ra = {5'd3, 5'd7};
      #2;
      total++; if (rd_a[63:32] !== 32'h12345678) begin bad++; $display("FAIL byp1_a got=%h exp=%h", rd_a[63:32], 32'h12345678); end
      total++; if (rd_b[63:32] !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp1_b got=%h exp=%h", rd_b[63:32], 32'hA5A5A5A5); end
      total++; if (rd_a[31:0] !== 32'h22222222) begin bad++; $display("FAIL byp1_other got=%h exp=%h", rd_a[31:0], 32'h22222222); end
      step(); idle();
      #2;
      total++; if (rd_a[63:32] !== 32'h12345678) begin bad++; $display("FAIL byp1_post_a got=%h exp=%h", rd_a[63:32], 32'h12345678); end
      total++; if (rd_b[63:32] !== 32'h12345678) begin bad++; $display("FAIL byp1_post_b got=%h exp=%h", rd_b[63:32], 32'h12345678); end
      we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'hCAFEF00D};
      #2;
      total++; if (rd_a[63:32] !== 32'hCAFEF00D) begin bad++; $display("FAIL byp0_a got=%h exp=%h", rd_a[63:32], 32'hCAFEF00D); end
      total++; if (rd_b[63:32] !== 32'h12345678) begin bad++; $display("FAIL byp0_b got=%h exp=%h", rd_b[63:32], 32'h12345678); end
      step(); idle();
   endtask

   task automatic test_zero();
      we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hFFFFFFFF};
      set_en = 1'b1; set_addr = 5'd0; ra = {5'd0, 5'd0};
      #2;
      total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL zero_cyc_rd_a got=%h exp=%h", rd_a, 64'h0); end
      total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL zero_cyc_pend_a got=%b exp=%b", pend_a, 2'b00); end
      total++; if (rd_b[31:0] !== 32'h0) begin bad++; $display("FAIL zero_cyc_rd_b got=%h exp=%h", rd_b[31:0], 32'h0); end
      step(); idle();
      #2;
      total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL zero_rd_a got=%h exp=%h", rd_a, 64'h0); end
      total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL zero_pend_a got=%b exp=%b", pend_a, 2'b00); end
      total++; if (rd_b !== {2{32'hFFFFFFFF}}) begin bad++; $display("FAIL zero_rd_b got=%h exp=%h", rd_b, {2{32'hFFFFFFFF}}); end
      total++; if (pend_b !== 2'b11) begin bad++; $display("FAIL zero_pend_b got=%b exp=%b", pend_b, 2'b11); end
      we = 2'b10; wa = {5'd0, 5'd0}; wd = {32'h12345678, 32'h0};
      #2;
      total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL zero_byp1_a got=%h exp=%h", rd_a, 64'h0); end
      step(); idle();
      #2;
      total++; if (rd_b[31:0] !== 32'h12345678) begin bad++; $display("FAIL zero_w1_b got=%h exp=%h", rd_b[31:0], 32'h12345678); end
      total++; if (pend_b !== 2'b00) begin bad++; $display("FAIL zero_clr_b got=%b exp=%b", pend_b, 2'b00); end
   endtask

   task automatic test_scoreboard();
      step();
      set_en = 1'b1; set_addr = 5'd9; ra = {5'd10, 5'd9};
      #2;
      total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL sb_early got=%b exp=%b", pend_a, 2'b00); end
      step(); idle(); ra = {5'd9, 5'd9};
      #2;
      total++; if (pend_a !== 2'b11) begin bad++; $display("FAIL sb_set_a got=%b exp=%b", pend_a, 2'b11); end
      total++; if (pend_b !== 2'b11) begin bad++; $display("FAIL sb_set_b got=%b exp=%b", pend_b, 2'b11); end
      we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h00000099};
      #2;
      total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL sb_wcyc_a got=%b exp=%b", pend_a, 2'b00); end
      total++; if (pend_b !== 2'b11) begin bad++; $display("FAIL sb_wcyc_b got=%b exp=%b", pend_b, 2'b11); end
      total++; if (rd_a[31:0] !== 32'h99) begin bad++; $display("FAIL sb_wcyc_rd_a got=%h exp=%h", rd_a[31:0], 32'h99); end
      total++; if (rd_b[31:0] !== 32'h0) begin bad++; $display("FAIL sb_wcyc_rd_b got=%h exp=%h", rd_b[31:0], 32'h0); end
      step(); idle();
      #2;
      total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL sb_clr_a got=%b exp=%b", pend_a, 2'b00); end
      total++; if (pend_b !== 2'b00) begin bad++; $display("FAIL sb_clr_b got=%b exp=%b", pend_b, 2'b00); end
      total++; if (rd_b[31:0] !== 32'h99) begin bad++; $display("FAIL sb_clr_rd_b got=%h exp=%h", rd_b[31:0], 32'h99); end
      we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h00000077}; set_en = 1'b1; set_addr = 5'd9;
      #2;
      total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL sb_ws_cyc got=%b exp=%b", pend_a, 2'b00); end
      step(); idle();
      #2;
      total++; if (pend_a !== 2'b11) begin bad++; $display("FAIL sb_ws_a got=%b exp=%b", pend_a, 2'b11); end
      total++; if (pend_b !== 2'b11) begin bad++; $display("FAIL sb_ws_b got=%b exp=%b", pend_b, 2'b11); end
      total++; if (rd_a[31:0] !== 32'h77) begin bad++; $display("FAIL sb_ws_rd got=%h exp=%h", rd_a[31:0], 32'h77); end
      ra = {5'd10, 5'd9};
      #2;
      total++; if (pend_a !== 2'b01) begin bad++; $display("FAIL sb_indep got=%b exp=%b", pend_a, 2'b01); end
      we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h00000055}; set_en = 1'b1; set_addr = 5'd10;
      #2;
      total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL sb_mix_cyc got=%b exp=%b", pend_a, 2'b00); end
      step(); idle();
      #2;
      total++; if (pend_a !== 2'b10) begin bad++; $display("FAIL sb_mix got=%b exp=%b", pend_a, 2'b10); end
      total++; if (rd_a[31:0] !== 32'h55) begin bad++; $display("FAIL sb_mix_rd got=%h exp=%h", rd_a[31:0], 32'h55); end
      reset = 1'b1;
      #2;
      total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL sb_rsthold_pend got=%b exp=%b", pend_a, 2'b00); end
      total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL sb_rsthold_rd got=%h exp=%h", rd_a, 64'h0); end
      step(); reset = 1'b0;
      #2;
      total++; if (pend_a !== 2'b00) begin bad++; $display("FAIL sb_rst_pend_a got=%b exp=%b", pend_a, 2'b00); end
      total++; if (pend_b !== 2'b00) begin bad++; $display("FAIL sb_rst_pend_b got=%b exp=%b", pend_b, 2'b00); end
      total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL sb_rst_rd got=%h exp=%h", rd_a, 64'h0); end
   endtask

   task automatic test_sweep();
      logic [15:0] exp;
      step();
      for (int k = 1; k < 8; k++) begin
         s_we = (k % 2 == 1) ? 2'b10 : 2'b01;
         s_wa = {3'(k), 3'(k)};
         s_wd = {16'(k * 257), 16'(k * 257)};
         step();
      end
      idle();
      for (int k = 0; k < 8; k++) begin
         s_ra = {3'(k + 3), 3'(k + 2), 3'(k + 1), 3'(k)};
         #1;
         for (int j = 0; j < 4; j++) begin
            exp = 16'(((k + j) % 8) * 257);
            total++; if (s_rd[j*16 +: 16] !== exp) begin bad++; $display("FAIL sw_rd k=%0d j=%0d got=%h exp=%h", k, j, s_rd[j*16 +: 16], exp); end
         end
         total++; if (s_pend !== 4'h0) begin bad++; $display("FAIL sw_pend k=%0d got=%b exp=%b", k, s_pend, 4'h0); end
      end
      step();
      s_set_en = 1'b1; s_set_addr = 3'd6;
      step(); idle(); s_ra = {4{3'd6}};
      #2;
      total++; if (s_pend !== 4'hF) begin bad++; $display("FAIL sw_set got=%b exp=%b", s_pend, 4'hF); end
      total++; if (s_rd[15:0] !== 16'h0606) begin bad++; $display("FAIL sw_r6 got=%h exp=%h", s_rd[15:0], 16'h0606); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #2;
      for (int k = 0; k < 8; k++) begin
         s_ra = {3'(k + 3), 3'(k + 2), 3'(k + 1), 3'(k)};
         #1;
         total++; if (s_rd !== 64'h0) begin bad++; $display("FAIL sw_rst_rd k=%0d got=%h exp=%h", k, s_rd, 64'h0); end
         total++; if (s_pend !== 4'h0) begin bad++; $display("FAIL sw_rst_pend k=%0d got=%b exp=%b", k, s_pend, 4'h0); end
      end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      wa = '0; wd = '0; ra = '0; set_addr = '0;
      s_wa = '0; s_wd = '0; s_ra = '0; s_set_addr = '0;
      step();
      step();
      test_reset();
      test_conflict();
      test_bypass();
      test_zero();
      test_scoreboard();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the next-generation MIPS core. It has NRD combinational read ports and two clocked write ports with fixed priority. Optional same-cycle write-to-read bypass and an optional hardwired zero register are set by parameters. A per-register pending scoreboard lets the control path stall on read-after-write hazards. It replaces the fixed 2R1W, 32x32 file in the datapath.

Parameters:
WIDTH  32  data width of each register, in bits
AW  5  address width; DEPTH = 2**AW registers
NRD  2  number of read ports (1..4)
ZERO_REG  1  1: register 0 reads as 0, ignores writes, is never pending
BYPASS  1  1: a read of an address being written this cycle returns the write data

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
we  in  2  write enables; bit i enables write port i
wa  in  2*AW  write addresses; port i is wa[i*AW +: AW]
wd  in  2*WIDTH  write data; port i is wd[i*WIDTH +: WIDTH]
ra  in  NRD*AW  read addresses; port j is ra[j*AW +: AW]
rd  out  NRD*WIDTH  read data; port j is rd[j*WIDTH +: WIDTH]
set_en  in  1  mark register set_addr as pending (a producer has issued)
set_addr  in  AW  register to mark pending
rd_pend  out  NRD  bit j=1: register ra[j] is pending, data not valid

Behaviour:
- Reset: on a rising edge with reset=1, all DEPTH registers and all pending bits go to 0. Reset overrides we and set_en in that cycle.
- While reset=1, rd and rd_pend are forced to 0 combinationally, with bypass gated off. After reset releases, every rd reads 0 and every rd_pend reads 0.
- Write: on a rising edge with reset=0 and we[i]=1, register wa[i] takes wd[i].
- Write conflict: if both ports write the same address in one cycle, port 1's data is stored.
- ZERO_REG=1: writes to address 0 are dropped, set_en to address 0 is dropped, reads of address 0 return 0 and rd_pend=0, bypass included.
- Read: combinational; rd[j] = mem[ra[j]]. Zero added latency.
- Bypass, BYPASS=1: if we[i]=1 and wa[i]==ra[j] in the same cycle, rd[j] = wd[i]. Port 1 has priority over port 0, and the zero-register rule has priority over bypass.
- BYPASS=0: a read in the same cycle as the write returns the old value; the new value is visible in the cycle after the edge.
- Scoreboard state: one pending bit per register, updated on the rising edge.
  - A write with we[i]=1 clears pend[wa[i]].
  - set_en=1 sets pend[set_addr].
  - Same address cleared and set in one cycle: set wins, because the new producer supersedes the old one.
- rd_pend[j] = pend[ra[j]], with one exception: when BYPASS=1 and a write to ra[j] occurs this cycle, rd_pend[j]=0, because the bypassed data is valid.
- Reads of any address and the scoreboard are independent of each other. Multiple read ports may address the same register.
- No X propagation: every rd bit is driven for every address in 0..DEPTH-1.

Test Plan:
1. Reset, then read all addresses on all ports -> every rd=0, every rd_pend=0. Then write 0xDEADBEEF to r5 while reset=1 -> r5 still reads 0 after reset drops.
2. Dual-port conflict: we=2'b11, wa0=wa1=7, wd0=0x11111111, wd1=0x22222222 -> next cycle rd[0] (ra=7) = 0x22222222. Same cycle with BYPASS=1 -> rd=0x22222222.
3. Bypass check: r3 holds 0xA5A5A5A5; write 0x12345678 to r3 while ra[1]=3 -> BYPASS=1: rd[1]=0x12345678 in the same cycle; BYPASS=0: 0xA5A5A5A5, then 0x12345678 next cycle.
4. Zero register: write 0xFFFFFFFF to r0 and set_en to r0 -> rd=0 and rd_pend=0 on all ports for ZERO_REG=1. With ZERO_REG=0, rd=0xFFFFFFFF after the edge.
5. Scoreboard: set_en r9 -> rd_pend=1 on the next cycle with ra=9. Write r9 with BYPASS=1 -> rd_pend=0 in the write cycle. Same-cycle write r9 + set_en r9 -> pend stays 1.
6. Parameter sweep WIDTH=16, AW=3, NRD=4: write address k with value k*0x0101 for k=1..7, read on all 4 ports -> values match. A mid-sequence reset pulse -> all reads 0.
